// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory adaptor: FSM state encoding,
// line/beat geometry and the line-alignment helper.
package rv32i_types;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BURST_BEATS = 4;

  localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    idle     = 2'd0,
    rd_burst = 2'd1,
    wr_burst = 2'd2,
    done     = 2'd3
  } adaptor_states;

  // Clears the byte-within-line offset so memory always sees a line-aligned address.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~32'h0000_001f;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line request into a four-beat 64-bit memory burst.
// Optional macro ADAPTOR_EARLY_RESP_EN: read completion is signalled in the cycle of the last beat.
module cacheline_adaptor
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,

  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  adaptor_states     state_q, state_d;
  logic [1:0]        cnt_q;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       addr_q;

  logic last_beat;
  assign last_beat = resp_i && (cnt_q == LAST_BEAT);

  // NOTE: the line buffer is an ordinary flop array, so it is reset like any
  // other state; that keeps line_o at zero whenever rst is low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= idle;
      cnt_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        idle: begin
          if (write_i || read_i) begin
            addr_q <= line_align(address_i);
            cnt_q  <= '0;
            if (write_i) line_q <= line_i;
          end
        end
        rd_burst: begin
          if (resp_i) begin
            line_q[BEAT_W*cnt_q +: BEAT_W] <= burst_i;
            cnt_q <= cnt_q + 2'd1;
          end
        end
        wr_burst: begin
          // cnt wraps 3 -> 0 on the final beat, ready for the next accept.
          if (resp_i) cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a latch behind.
  always_comb begin
    state_d = state_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    line_o  = line_q;
    case (state_q)
      idle: begin
        if (write_i)     state_d = wr_burst;
        else if (read_i) state_d = rd_burst;
      end
      rd_burst: begin
        read_o = 1'b1;
        if (last_beat) begin
`ifdef ADAPTOR_EARLY_RESP_EN
          state_d = idle;
          resp_o  = 1'b1;
          line_o  = {burst_i, line_q[3*BEAT_W-1:0]};
`else
          state_d = done;
`endif
        end
      end
      wr_burst: begin
        write_o = 1'b1;
        if (last_beat) state_d = done;
      end
      done: begin
        resp_o  = 1'b1;
        state_d = idle;
      end
      default: state_d = idle;
    endcase
  end

  // Beat 0 is line[63:0]; the beat holds through gaps because cnt only moves on resp_i.
  assign burst_o   = (state_q == wr_burst) ? line_q[BEAT_W*cnt_q +: BEAT_W] : '0;
  assign address_o = addr_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed table, reset and idle
// corner sequences, then randomized transactions against a line-level model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

`ifdef ADAPTOR_EARLY_RESP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit           wr;
    bit           rd;
    logic [31:0]  addr;
    logic [255:0] line;      // line_i driven with the request
    logic [255:0] beats;     // memory read data, beat k = beats[64k +: 64]
    int           gaps [4];  // idle cycles before beat k
    logic [31:0]  exp_addr;
    logic [255:0] exp_line;  // expected line_o at completion (and write beat source)
  } vec_t;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Drives one full line transaction and checks every cycle of it.
  task automatic run_txn(input vec_t v, input string tag);
    bit   is_wr;
    int   cyc;
    int   lat;
    int   exp_lat;
    is_wr   = v.wr;
    exp_lat = (EARLY && !is_wr) ? 5 : 6;
    for (int k = 0; k < 4; k++) exp_lat += v.gaps[k];
    lat = -1;

    @(posedge clk); #1;
    address_i = v.addr;
    line_i    = v.line;
    read_i    = v.rd;
    write_i   = v.wr;
    resp_i    = 1'b0;
    burst_i   = '0;
    cyc       = 0;
    @(negedge clk);
    check({tag, " req-cycle busy"}, {read_o, write_o, resp_o}, 3'b000);

    @(posedge clk); #1; cyc++;
    @(negedge clk);
    check({tag, " read_o"},    read_o,    !is_wr);
    check({tag, " write_o"},   write_o,   is_wr);
    check({tag, " address_o"}, address_o, v.exp_addr);

    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < v.gaps[k]; g++) begin
        @(posedge clk); #1; cyc++;
        resp_i  = 1'b0;
        burst_i = 64'($urandom);
        @(negedge clk);
        check({tag, " gap strobe"}, {read_o, write_o, resp_o}, {!is_wr, is_wr, 1'b0});
        check({tag, " gap address_o"}, address_o, v.exp_addr);
        if (is_wr) check({tag, " gap burst_o"}, burst_o, v.exp_line[64*k +: 64]);
      end
      @(posedge clk); #1; cyc++;
      resp_i  = 1'b1;
      burst_i = is_wr ? 64'({$urandom, $urandom}) : v.beats[64*k +: 64];
      @(negedge clk);
      check({tag, " beat strobe"}, {read_o, write_o}, {!is_wr, is_wr});
      check({tag, " beat address_o"}, address_o, v.exp_addr);
      if (is_wr) check({tag, " beat burst_o"}, burst_o, v.exp_line[64*k +: 64]);
      if (EARLY && !is_wr && k == 3) begin
        check({tag, " early resp_o"}, resp_o, 1'b1);
        check({tag, " early line_o"}, line_o, v.exp_line);
        if (resp_o) lat = cyc;
        read_i  = 1'b0;
        write_i = 1'b0;
      end else begin
        check({tag, " beat resp_o"}, resp_o, 1'b0);
      end
    end

    @(posedge clk); #1; cyc++;
    resp_i  = 1'b0;
    burst_i = '0;
    @(negedge clk);
    check({tag, " post strobe"}, {read_o, write_o}, 2'b00);
    check({tag, " post line_o"}, line_o, v.exp_line);
    if (EARLY && !is_wr) begin
      check({tag, " post resp_o"}, resp_o, 1'b0);
    end else begin
      check({tag, " resp_o"}, resp_o, 1'b1);
      if (resp_o) lat = cyc;
      read_i  = 1'b0;
      write_i = 1'b0;
    end

    @(posedge clk); #1; cyc++;
    @(negedge clk);
    check({tag, " after resp_o"}, {read_o, write_o, resp_o}, 3'b000);
    check({tag, " line_o stable"}, line_o, v.exp_line);
    check({tag, " latency"}, 256'(lat), 256'(exp_lat));
  endtask

  vec_t tbl [4];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;

    // Directed vectors.
    tbl[0] = '{wr: 1'b0, rd: 1'b1, addr: 32'h1234_5678, line: '0,
               beats: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
               gaps: '{0, 0, 0, 0}, exp_addr: 32'h1234_5660,
               exp_line: {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}};
    tbl[1] = '{wr: 1'b1, rd: 1'b0, addr: 32'h8000_003f,
               line: {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}},
               beats: '0, gaps: '{0, 0, 2, 0}, exp_addr: 32'h8000_0020,
               exp_line: {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}};
    tbl[2] = '{wr: 1'b1, rd: 1'b1, addr: 32'h0000_0040,
               line: {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                      64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_0f0f_f0f0},
               beats: {4{64'hdead_beef_dead_beef}}, gaps: '{0, 0, 0, 0},
               exp_addr: 32'h0000_0040,
               exp_line: {64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210,
                          64'h5555_aaaa_5555_aaaa, 64'h0f0f_f0f0_0f0f_f0f0}};
    tbl[3] = '{wr: 1'b0, rd: 1'b1, addr: 32'hffff_ffff, line: {4{64'h1}},
               beats: {64'h8, 64'h4, 64'h2, 64'h1}, gaps: '{1, 0, 3, 1},
               exp_addr: 32'hffff_ffe0, exp_line: {64'h8, 64'h4, 64'h2, 64'h1}};

    #12;
    check("reset line_o",    line_o,    '0);
    check("reset burst_o",   burst_o,   '0);
    check("reset address_o", address_o, '0);
    check("reset strobes",   {read_o, write_o, resp_o}, 3'b000);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // resp_i while idle must be ignored.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      resp_i = 1'b1;
      @(negedge clk);
      check("idle resp_i strobes", {read_o, write_o, resp_o}, 3'b000);
      check("idle resp_i address_o", address_o, tbl[3].exp_addr);
    end
    @(posedge clk); #1;
    resp_i = 1'b0;
    run_txn(tbl[0], "after-idle-resp");

    // Reset asserted after two read beats.
    @(posedge clk); #1;
    address_i = 32'h0bad_f00d; read_i = 1'b1;
    @(posedge clk); #1;
    resp_i = 1'b1; burst_i = 64'hcafe_cafe_cafe_cafe;
    @(posedge clk); #1;
    burst_i = 64'h1357_9bdf_2468_ace0;
    @(posedge clk); #1;
    resp_i = 1'b0; read_i = 1'b0;
    check("pre-reset read_o", read_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid-reset line_o",    line_o,    '0);
    check("mid-reset burst_o",   burst_o,   '0);
    check("mid-reset address_o", address_o, '0);
    check("mid-reset strobes",   {read_o, write_o, resp_o}, 3'b000);
    @(negedge clk);
    rst = 1'b1;
    run_txn(tbl[0], "post-reset");

    // Randomized transactions against the line-level model.
    for (int t = 0; t < 25; t++) begin
      rv.wr    = 1'($urandom_range(0, 1));
      rv.rd    = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.addr  = $urandom;
      rv.line  = rand_line();
      rv.beats = rand_line();
      for (int k = 0; k < 4; k++) rv.gaps[k] = $urandom_range(0, 2);
      rv.exp_addr = (rv.addr / 32) * 32;
      rv.exp_line = rv.wr ? rv.line : rv.beats;
      run_txn(rv, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

- Bridges the cache/eviction-write-buffer side line interface (one 256-bit line per request) to the physical memory burst interface (four 64-bit beats per line).
- Acts as the responder to the cache and the eviction write buffer; the read/write/resp handshake they initiate terminates here.
- Acts as the initiator toward main memory.
- Sits between the cache hierarchy's memory port and the DRAM model.

## Interface
Parameters: none. Line width 256 and beat width 64 are fixed.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- line_i  in  256  write line from cache side
- line_o  out  256  read line to cache side
- address_i  in  32  byte address of request
- read_i  in  1  line read request, held until resp_o
- write_i  in  1  line write request, held until resp_o
- resp_o  out  1  transaction complete, one-cycle pulse
- burst_i  in  64  read beat from memory
- burst_o  out  64  write beat to memory
- address_o  out  32  line-aligned memory address
- read_o  out  1  burst read request
- write_o  out  1  burst write request
- resp_i  in  1  memory beat acknowledge, one per beat

## Operation
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: if write_i, accept a write; else if read_i, accept a read. Write wins on simultaneous read_i and write_i.
- On accept:
  - address_o <= {address_i[31:5], 5'b0}.
  - Beat counter cnt <= 0.
  - For writes, line buffer <= line_i.
  - Go to WR_BURST or RD_BURST.
- RD_BURST:
  - read_o = 1.
  - Each cycle with resp_i = 1: buffer[64*cnt +: 64] <= burst_i; cnt <= cnt + 1.
  - resp_i with cnt == 3 goes to DONE.
- WR_BURST:
  - write_o = 1; burst_o = buffer[64*cnt +: 64], so beat 0 is line[63:0].
  - Each resp_i advances cnt; resp_i with cnt == 3 goes to DONE.
- DONE: resp_o = 1 for exactly one cycle, then go to IDLE. Requests are ignored in DONE.
- line_o = line buffer. It is stable from the resp_o cycle until the next accepted request.
- cnt is 2 bits and wraps 3 -> 0 only on exit from a burst state.
- resp_i in IDLE or DONE is ignored.
- Requester obligation: deassert read_i/write_i in the resp_o cycle. A request still high in the following IDLE cycle starts a new transaction.
- Reset, whenever asserted, including mid-burst:
  - State IDLE; cnt 0; buffer 0.
  - All outputs 0: line_o, burst_o, address_o, read_o, write_o, resp_o.

## Timing
- Outputs read_o, write_o and resp_o decode from registered state only (Moore). burst_o and line_o are registered-path.
- Request seen at edge N: read_o or write_o high from cycle N+1.
- A beat is consumed at the edge where resp_i = 1. Gaps between resp_i pulses are allowed; burst_o and address_o hold through gaps.
- read_o/write_o deassert the cycle after the 4th resp_i.
- resp_o asserts in that same cycle.
- Minimum request-to-resp_o latency with back-to-back resp_i: 6 cycles.

## Configuration
- Macro ADAPTOR_EARLY_RESP_EN.
- Defined:
  - In RD_BURST, a resp_i with cnt == 3 asserts resp_o combinationally in that same cycle.
  - line_o = {burst_i, buffer[191:0]} during that cycle. The buffer is also written.
  - Next state is IDLE (DONE is skipped).
  - Writes are unchanged.
- Undefined: behaviour as above. resp_o is purely registered-state.

## Structure
- rv32i_types gains:
  - enum adaptor_states {idle, rd_burst, wr_burst, done}, 2 bits.
  - Constant BURST_BEATS = 4.
- No sub-module: the counter and line buffer stay inline.
- Top module name: cacheline_adaptor.

## Test plan
- Read, address_i 0x1234_5678, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i:
  - address_o = 0x1234_5660.
  - line_o = {44..,33..,22..,11..}.
  - One resp_o pulse, 6 cycles after request.
- Write, line_i = {D,C,B,A}, 2 idle cycles between beats 1 and 2:
  - burst_o = A, B, C, D in order.
  - B is held during the gap.
  - resp_o after D.
- read_i and write_i asserted together: write_o asserts, read_o stays 0.
- rst low after 2 read beats:
  - All outputs 0 immediately.
  - A fresh read afterwards completes with the correct line.
- resp_i pulsed while IDLE for 3 cycles: no state change, no resp_o.
- With ADAPTOR_EARLY_RESP_EN, read:
  - resp_o is in the same cycle as the 4th resp_i.
  - line_o is correct in that cycle.
  - Latency is 5 cycles.
